// File: rtl/gsim_host_pkg.sv
// Shared sizes, defaults and the sequencer state encoding for the GSIM host sequencer.
package gsim_host_pkg;

    localparam int N           = 16;
    localparam int B_W         = 16;
    localparam int X_W         = 32;
    localparam int TIMEOUT_DEF = 8192;

    // Buffer index width and capture counter width (the counter must reach N)
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/gsim_regbuf.sv
// Register array with one synchronous write port and one read address.
// The read address feeds both a registered output (reset to zero) and an
// unregistered output, so the same block serves the streamed b buffer and
// the host-readable x buffer. A read of the address being written returns
// the old contents.
module gsim_regbuf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data_q,
    output logic [WIDTH-1:0] rd_data_comb
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data_comb = mem[rd_addr];

endmodule

// File: rtl/gsim_host_seq.sv
// Host-side sequencer for the GSIM solver: buffers 16 b words from the host,
// streams them into GSIM as one contiguous in_en burst, then captures the
// 16-word x result window into a host-readable buffer and reports status.
module gsim_host_seq
    import gsim_host_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [B_W-1:0]   wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             short_err,
    output logic [CNT_W-1:0] cap_cnt,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [X_W-1:0]   rd_data,
    output logic             gs_in_en,
    output logic [B_W-1:0]   gs_b,
    input  logic             gs_out_valid,
    input  logic [X_W-1:0]   gs_x
);

    localparam int TW = $clog2(TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic             timeout_q, timeout_d;
    logic             short_err_q, short_err_d;

    logic             bbuf_wr_en;
    logic [B_W-1:0]   bbuf_rd;
    logic [B_W-1:0]   bbuf_q_unused;
    logic             xbuf_wr_en;
    logic [IDX_W-1:0] xbuf_wr_addr;
    logic [X_W-1:0]   xbuf_comb_unused;

    // Host writes are accepted only while idle, including the start cycle
    assign bbuf_wr_en = wr_en && (state_q == IDLE);

    // x words land at index 0 on the first valid in WAIT, then in arrival order
    always_comb begin
        xbuf_wr_en   = 1'b0;
        xbuf_wr_addr = '0;
        if (gs_out_valid && (state_q == WAIT)) begin
            xbuf_wr_en = 1'b1;
        end else if (gs_out_valid && (state_q == CAPTURE)) begin
            xbuf_wr_en   = 1'b1;
            xbuf_wr_addr = cap_cnt_q[IDX_W-1:0];
        end
    end

    gsim_regbuf #(.WIDTH(B_W), .DEPTH(N)) u_bbuf (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (bbuf_wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (idx_q),
        .rd_data_q    (bbuf_q_unused),
        .rd_data_comb (bbuf_rd)
    );

    gsim_regbuf #(.WIDTH(X_W), .DEPTH(N)) u_xbuf (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (xbuf_wr_en),
        .wr_addr      (xbuf_wr_addr),
        .wr_data      (gs_x),
        .rd_addr      (rd_addr),
        .rd_data_q    (rd_data),
        .rd_data_comb (xbuf_comb_unused)
    );

    // Next-state and status computation for the run sequence
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        cap_cnt_d   = cap_cnt_q;
        timeout_d   = timeout_q;
        short_err_d = short_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    cap_cnt_d   = '0;
                    timeout_d   = 1'b0;
                    short_err_d = 1'b0;
                end
            end
            SEND: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (gs_out_valid) begin
                    cap_cnt_d = CNT_W'(1);
                    state_d   = CAPTURE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            CAPTURE: begin
                if (gs_out_valid) begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (cap_cnt_q == CNT_W'(N - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    short_err_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register; reset aborts any run at the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            cap_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            cap_cnt_q   <= cap_cnt_d;
            timeout_q   <= timeout_d;
            short_err_q <= short_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign timeout   = timeout_q;
    assign short_err = short_err_q;
    assign cap_cnt   = cap_cnt_q;
    assign gs_in_en  = (state_q == SEND);
    assign gs_b      = gs_in_en ? bbuf_rd : '0;

endmodule

// File: tb/tb_gsim_host_seq.sv
// Directed bench for gsim_host_seq: b streaming, x capture, timeout,
// short window, write/start interactions and mid-run reset.
module tb_gsim_host_seq;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        start_to;
    logic [3:0]  rd_addr;
    logic        gs_out_valid;
    logic        valid_to;
    logic [31:0] gs_x;

    logic        busy, done, timeout, short_err, gs_in_en;
    logic [4:0]  cap_cnt;
    logic [31:0] rd_data;
    logic [15:0] gs_b;

    logic        to_busy, to_done, to_timeout, to_short_err, to_gs_in_en;
    logic [4:0]  to_cap_cnt;
    logic [31:0] to_rd_data;
    logic [15:0] to_gs_b;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_b [16];

    gsim_host_seq dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .timeout(timeout), .short_err(short_err),
        .cap_cnt(cap_cnt), .rd_addr(rd_addr), .rd_data(rd_data), .gs_in_en(gs_in_en),
        .gs_b(gs_b), .gs_out_valid(gs_out_valid), .gs_x(gs_x)
    );

    // Short-timeout instance, started only for the timeout scenario
    gsim_host_seq #(.TIMEOUT(64)) dut_to (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_to), .busy(to_busy), .done(to_done), .timeout(to_timeout),
        .short_err(to_short_err), .cap_cnt(to_cap_cnt), .rd_addr(rd_addr),
        .rd_data(to_rd_data), .gs_in_en(to_gs_in_en), .gs_b(to_gs_b),
        .gs_out_valid(valid_to), .gs_x(gs_x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        tick();
        chk("rd_data", rd_data, exp);
        $display("read x[%0d] = %h", addr, rd_data);
    endtask

    // Pulse start and check the 16-cycle contiguous burst; optional write mid-burst
    task automatic run_send(input bit mid_wr);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            chk("send_in_en", gs_in_en, 1);
            chk("send_b", gs_b, exp_b[i]);
            if (mid_wr && i == 2) begin
                wr_en   = 1'b1;
                wr_addr = 4'd3;
                wr_data = 16'h7777;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        chk("in_en_after_burst", gs_in_en, 0);
        chk("gs_b_after_burst", gs_b, 0);
        chk("busy_in_wait", busy, 1);
        $display("send run: b0=%h b15=%h", exp_b[0], exp_b[15]);
    endtask

    initial begin
        int send_cnt;
        int wait_cnt;
        bit seen;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        start_to = 1'b0; rd_addr = '0; gs_out_valid = 1'b0; valid_to = 1'b0; gs_x = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_short_err", short_err, 0);
        chk("rst_cap_cnt", cap_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_in_en", gs_in_en, 0);
        chk("rst_gs_b", gs_b, 0);
        chk("rst_to_busy", to_busy, 0);
        reset = 1'b0;

        // Load b[i] = i+1
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 16'(i + 1);
            exp_b[i] = 16'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_in_en", gs_in_en, 0);

        // Full run; write during SEND must not disturb the burst
        run_send(1'b1);

        // 100-cycle gap with a start pulse during WAIT that must be ignored
        for (int c = 0; c < 100; c++) begin
            start = (c == 50);
            tick();
            if (c == 50) begin
                chk("wait_start_busy", busy, 1);
                chk("wait_start_in_en", gs_in_en, 0);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gs_out_valid = 1'b1;
            gs_x = 32'h1000_0000 + 32'(i);
            tick();
            if (i < 15) chk("cap_no_done", done, 0);
        end
        gs_out_valid = 1'b0;
        chk("full_done", done, 1);
        chk("full_busy_in_done", busy, 1);
        chk("full_cap_cnt", cap_cnt, 16);
        chk("full_timeout", timeout, 0);
        chk("full_short_err", short_err, 0);
        tick();
        chk("full_done_pulse", done, 0);
        chk("full_idle", busy, 0);
        chk("full_cap_hold", cap_cnt, 16);
        rd_chk(4'd5, 32'h1000_0005);
        rd_chk(4'd0, 32'h1000_0000);
        rd_chk(4'd15, 32'h1000_000F);

        // Timeout on the 64-cycle instance
        start_to = 1'b1;
        tick();
        start_to = 1'b0;
        send_cnt = 0;
        wait_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (to_done) begin
                seen = 1'b1;
                break;
            end
            if (to_gs_in_en) send_cnt++;
            else if (to_busy) wait_cnt++;
            tick();
        end
        chk("to_done_seen", 32'(seen), 1);
        chk("to_send_cycles", send_cnt, 16);
        chk("to_wait_cycles", wait_cnt, 64);
        chk("to_timeout", to_timeout, 1);
        chk("to_cap_cnt", to_cap_cnt, 0);
        chk("to_short_err", to_short_err, 0);
        chk("main_dut_idle", busy, 0);
        $display("timeout run: send=%0d wait=%0d", send_cnt, wait_cnt);
        tick();

        // Short window: 10 words then valid drops
        run_send(1'b0);
        for (int c = 0; c < 5; c++) tick();
        for (int i = 0; i < 10; i++) begin
            gs_out_valid = 1'b1;
            gs_x = 32'h2000_0000 + 32'(i);
            tick();
        end
        gs_out_valid = 1'b0;
        tick();
        chk("short_done", done, 1);
        chk("short_err_flag", short_err, 1);
        chk("short_cap_cnt", cap_cnt, 10);
        chk("short_timeout", timeout, 0);
        tick();
        rd_chk(4'd0, 32'h2000_0000);
        rd_chk(4'd9, 32'h2000_0009);
        rd_chk(4'd10, 32'h1000_000A);
        rd_chk(4'd15, 32'h1000_000F);

        // Write and start in the same cycle: new b[0] is transmitted
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hABCD;
        exp_b[0] = 16'hABCD;
        run_send(1'b0);

        // Reset mid-WAIT aborts the run and clears status
        for (int c = 0; c < 3; c++) tick();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_en", gs_in_en, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_short_err", short_err, 0);
        chk("mid_rst_cap_cnt", cap_cnt, 0);
        chk("mid_rst_to_timeout", to_timeout, 0);
        reset = 1'b0;
        tick();

        // Fresh run after reset; b buffer retained
        run_send(1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
